// File: rtl/isa.sv
// Shared RV32 ISA definitions: load/store funct3 codes, instruction word type
// and the canonical NOP used as the fetch reset value.
package isa;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef logic [31:0] instruction_t;

    localparam instruction_t INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/riscv_mem_align.sv
// Lane steering for data accesses: byte enables, store replication, load
// extraction/extension and misalignment check (RISCV_MEM_SUBWORD_EN).
module riscv_mem_align
    import isa::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      size_i,
    input  logic [1:0]      addr_lo_i,
    input  logic            write_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [31:0]     rword_i,
    output logic [3:0]      be_o,
    output logic [31:0]     wword_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            fault_o
);

`ifdef RISCV_MEM_SUBWORD_EN
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        shifted = rword_i >> {addr_lo_i, 3'b000};
        b       = shifted[7:0];
        h       = shifted[15:0];
        be_o    = '0;
        wword_o = wdata_i[31:0];
        rdata_o = '0;
        fault_o = 1'b0;
        case (size_i)
            FUNCT3_LB: begin
                be_o    = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
                rdata_o = {{(XLEN-8){b[7]}}, b};
            end
            FUNCT3_LH: begin
                fault_o = addr_lo_i[0];
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
                rdata_o = {{(XLEN-16){h[15]}}, h};
            end
            FUNCT3_LW: begin
                fault_o = (addr_lo_i != 2'b00);
                be_o    = 4'b1111;
                rdata_o = XLEN'(rword_i);
            end
            FUNCT3_LBU: begin
                fault_o = write_i;
                rdata_o = XLEN'(b);
            end
            FUNCT3_LHU: begin
                fault_o = write_i | addr_lo_i[0];
                rdata_o = XLEN'(h);
            end
            default: fault_o = 1'b1;
        endcase
        // A rejected access must neither write nor return data
        if (fault_o) begin
            be_o    = '0;
            rdata_o = '0;
        end
    end
`else
    logic unused_sub;
    assign unused_sub = ^{size_i, addr_lo_i, write_i};

    always_comb begin
        be_o    = 4'b1111;
        wword_o = wdata_i[31:0];
        rdata_o = XLEN'(rword_i);
        fault_o = 1'b0;
    end
`endif

endmodule

// File: rtl/riscv_mem.sv
// Fetch + data memory responder for riscv_hart with wait states.
// Sub-word accesses and faults are enabled by RISCV_MEM_SUBWORD_EN.
module riscv_mem
    import isa::*;
#(
    parameter int    XLEN      = 32,
    parameter int    DEPTH     = 1024,
    parameter int    WAIT      = 0,
    parameter string INIT_FILE = ""
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic [31:0]     instruction,
    input  logic            mem_req,
    input  logic            mem_write,
    input  logic [2:0]      mem_size,
    input  logic [XLEN-1:0] mem_addr,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] mem_read,
    output logic            mem_ack,
    output logic            mem_busy,
    output logic            mem_fault
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_M1 = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    logic [31:0]     mem_q [DEPTH];
    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW+1:0]   addr_q;
    logic [XLEN-1:0] data_q;
    logic            write_q;
    logic [2:0]      size_q;
    logic [XLEN-1:0] rdata_q;
    logic            fault_q;
    instruction_t    instr_q;

    logic            in_wait, accept, access, we;
    logic [AW+1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            a_write;
    logic [2:0]      a_size;
    logic [AW-1:0]   a_idx;
    logic [3:0]      be;
    logic [31:0]     wword;
    logic [XLEN-1:0] rdata;
    logic            fault;

    logic unused_addr;
    assign unused_addr = ^{pc[1:0], pc[XLEN-1:AW+2], mem_addr[XLEN-1:AW+2]};

    assign in_wait = (state_q == ST_WAIT);
    assign accept  = !in_wait && mem_req;
    assign access  = in_wait ? (cnt_q == 4'd0) : (mem_req && (WAIT == 0));

    assign a_addr  = in_wait ? addr_q  : mem_addr[AW+1:0];
    assign a_data  = in_wait ? data_q  : mem_data;
    assign a_write = in_wait ? write_q : mem_write;
    assign a_size  = in_wait ? size_q  : mem_size;
    assign a_idx   = a_addr[AW+1:2];
    assign we      = access && a_write && !fault && !rst;

    riscv_mem_align #(
        .XLEN(XLEN)
    ) u_align (
        .size_i   (a_size),
        .addr_lo_i(a_addr[1:0]),
        .write_i  (a_write),
        .wdata_i  (a_data),
        .rword_i  (mem_q[a_idx]),
        .be_o     (be),
        .wword_o  (wword),
        .rdata_o  (rdata),
        .fault_o  (fault)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_wait) begin
            if (cnt_q == 4'd0) state_d = ST_RESP;
            else               cnt_d   = cnt_q - 4'd1;
        end else if (mem_req) begin
            if (WAIT == 0) begin
                state_d = ST_RESP;
            end else begin
                state_d = ST_WAIT;
                cnt_d   = WAIT_M1;
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            instr_q <= INSTR_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= mem_q[pc[AW+1:2]];
            if (accept) begin
                addr_q  <= mem_addr[AW+1:0];
                data_q  <= mem_data;
                write_q <= mem_write;
                size_q  <= mem_size;
            end
            if (access) begin
                fault_q <= fault;
                if (fault)         rdata_q <= '0;
                else if (!a_write) rdata_q <= rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[a_idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
    end

    assign instruction = instr_q;
    assign mem_read    = rdata_q;
    assign mem_ack     = (state_q == ST_RESP);
    assign mem_busy    = in_wait;
    assign mem_fault   = mem_ack && fault_q;

endmodule

// File: tb/tb_riscv_mem.sv
// Directed bench for riscv_mem: one instance with no wait states, one with
// three; expectations follow RISCV_MEM_SUBWORD_EN when it is defined.
module tb_riscv_mem;

`ifdef RISCV_MEM_SUBWORD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;

    logic        clk, rst;
    logic [31:0] pc;
    logic [31:0] instr0, instr3;
    logic        req0, req3, wr;
    logic [2:0]  sz;
    logic [31:0] addr, wdata;
    logic [31:0] rd0, rd3;
    logic        ack0, ack3, busy0, busy3, flt0, flt3;

    int checks   = 0;
    int failures = 0;

    riscv_mem #(.XLEN(32), .DEPTH(1024), .WAIT(0), .INIT_FILE("")) u_dut0 (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instr0),
        .mem_req(req0), .mem_write(wr), .mem_size(sz), .mem_addr(addr),
        .mem_data(wdata), .mem_read(rd0), .mem_ack(ack0),
        .mem_busy(busy0), .mem_fault(flt0)
    );

    riscv_mem #(.XLEN(32), .DEPTH(1024), .WAIT(3), .INIT_FILE("")) u_dut3 (
        .clk(clk), .rst(rst), .pc(pc), .instruction(instr3),
        .mem_req(req3), .mem_write(wr), .mem_size(sz), .mem_addr(addr),
        .mem_data(wdata), .mem_read(rd3), .mem_ack(ack3),
        .mem_busy(busy3), .mem_fault(flt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic acc(input bit s3, input bit w, input logic [2:0] z,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic f,
                       output int lat);
        wr = w; sz = z; addr = a; wdata = d;
        if (s3) req3 = 1'b1;
        else    req0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        req3 = 1'b0;
        lat  = 1;
        while (!(s3 ? ack3 : ack0) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = s3 ? rd3 : rd0;
        f = s3 ? flt3 : flt0;
    endtask

    task automatic rd_chk(input string tag, input bit s3, input logic [2:0] z,
                          input logic [31:0] a, input logic [31:0] exp_d,
                          input bit exp_f);
        logic [31:0] r;
        logic        f;
        int          lat;
        acc(s3, 1'b0, z, a, 32'h0, r, f, lat);
        chk({tag, ".lat"}, lat, s3 ? 32'd4 : 32'd1);
        chk({tag, ".data"}, r, exp_d);
        chk({tag, ".fault"}, {31'b0, f}, {31'b0, exp_f});
    endtask

    task automatic wr_chk(input string tag, input bit s3, input logic [2:0] z,
                          input logic [31:0] a, input logic [31:0] d,
                          input bit exp_f);
        logic [31:0] r;
        logic        f;
        int          lat;
        acc(s3, 1'b1, z, a, d, r, f, lat);
        chk({tag, ".lat"}, lat, s3 ? 32'd4 : 32'd1);
        chk({tag, ".fault"}, {31'b0, f}, {31'b0, exp_f});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pc = 32'h8;
        req0 = 1'b0; req3 = 1'b0; wr = 1'b0;
        sz = W; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst.instr", instr0, 32'h0000_0013);
        chk("rst.ack", {31'b0, ack0}, 32'd0);
        chk("rst.busy", {31'b0, busy3}, 32'd0);
        chk("rst.fault", {31'b0, flt0}, 32'd0);
        chk("rst.rdata", rd0, 32'd0);
        rst = 1'b0;

        // Fetch: 1-cycle latency and read-before-write on the same word
        wr_chk("sw8a", 0, W, 32'h8, 32'h1111_1111, 0);
        @(negedge clk);
        chk("fetch.a", instr0, 32'h1111_1111);
        wr_chk("sw8b", 0, W, 32'h8, 32'h0050_0093, 0);
        chk("fetch.rbw", instr0, 32'h1111_1111);
        @(negedge clk);
        chk("fetch.new", instr0, 32'h0050_0093);
        pc = 32'hB;
        @(negedge clk);
        chk("fetch.lo", instr0, 32'h0050_0093);

        wr_chk("sw10", 0, W, 32'h10, 32'hDEAD_BEEF, 0);
        rd_chk("lw10", 0, W, 32'h10, 32'hDEAD_BEEF, 0);
        wr_chk("sb11", 0, B, 32'h11, 32'h80, 0);
        rd_chk("lb11", 0, B, 32'h11, SUB ? 32'hFFFF_FF80 : 32'h80, 0);
        rd_chk("lbu11", 0, BU, 32'h11, 32'h80, 0);
        rd_chk("lw10b", 0, W, 32'h10, SUB ? 32'hDEAD_80EF : 32'h80, 0);
        wr_chk("sh12", 0, H, 32'h12, 32'h1234, 0);
        rd_chk("lw10c", 0, W, 32'h10, SUB ? 32'h1234_80EF : 32'h1234, 0);
        rd_chk("lh10", 0, H, 32'h10, SUB ? 32'hFFFF_80EF : 32'h1234, 0);
        @(negedge clk);
        chk("hold.rdata", rd0, SUB ? 32'hFFFF_80EF : 32'h1234);
        chk("ack.pulse", {31'b0, ack0}, 32'd0);

        rd_chk("lh13", 0, H, 32'h13, SUB ? 32'h0 : 32'h1234, SUB);
        wr_chk("sw12", 0, W, 32'h12, 32'hCAFE_F00D, SUB);
        rd_chk("lw10d", 0, W, 32'h10, SUB ? 32'h1234_80EF : 32'hCAFE_F00D, 0);
        rd_chk("ld011", 0, 3'b011, 32'h10, SUB ? 32'h0 : 32'hCAFE_F00D, SUB);
        wr_chk("st100", 0, 3'b100, 32'h10, 32'h55, SUB);
        rd_chk("lw10e", 0, W, 32'h10, SUB ? 32'h1234_80EF : 32'h55, 0);

        // Request held through RESP is accepted back-to-back
        wr = 1'b1; sz = W; addr = 32'h30; wdata = 32'hA5A5_A5A5; req0 = 1'b1;
        @(negedge clk);
        chk("b2b.ack1", {31'b0, ack0}, 32'd1);
        wr = 1'b0;
        @(negedge clk);
        chk("b2b.ack2", {31'b0, ack0}, 32'd1);
        chk("b2b.rdata", rd0, 32'hA5A5_A5A5);
        req0 = 1'b0;
        @(negedge clk);
        chk("b2b.idle", {31'b0, ack0}, 32'd0);

        wr_chk("w3.sw20", 1, W, 32'h20, 32'h0BAD_F00D, 0);
        wr_chk("w3.sw24", 1, W, 32'h24, 32'h2424_2424, 0);

        // Busy window, with a store pulse mid-wait that must be dropped
        wr = 1'b0; sz = W; addr = 32'h20; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        chk("w3.busy1", {31'b0, busy3}, 32'd1);
        @(negedge clk);
        chk("w3.busy2", {31'b0, busy3}, 32'd1);
        wr = 1'b1; addr = 32'h24; wdata = 32'hFFFF_FFFF; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0; wr = 1'b0;
        chk("w3.busy3", {31'b0, busy3}, 32'd1);
        chk("w3.noack3", {31'b0, ack3}, 32'd0);
        @(negedge clk);
        chk("w3.ack4", {31'b0, ack3}, 32'd1);
        chk("w3.busy4", {31'b0, busy3}, 32'd0);
        chk("w3.rdata", rd3, 32'h0BAD_F00D);
        @(negedge clk);
        chk("w3.ack5", {31'b0, ack3}, 32'd0);
        rd_chk("w3.lw24", 1, W, 32'h24, 32'h2424_2424, 0);

        // Reset while a store is waiting discards it
        wr = 1'b1; sz = W; addr = 32'h20; wdata = 32'h1234_5678; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst3.ack", {31'b0, ack3}, 32'd0);
        chk("rst3.busy", {31'b0, busy3}, 32'd0);
        repeat (4) @(negedge clk);
        chk("rst3.noack", {31'b0, ack3}, 32'd0);
        rd_chk("rst3.lw20", 1, W, 32'h20, 32'h0BAD_F00D, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
